spi_master_arbiter: RTL and testbench
=====================================

SPI_MASTER_ARBITER -- requirements
Module: spi_master_arbiter

Interface
REQ-001 Parameter CLK_DIV, default 2, S_CLK half-period in CLK cycles; legal values 1..255.
REQ-002 CLK  input  1  single clock; all logic on rising edge.
REQ-003 CLR  input  1  asynchronous, active-low reset.
REQ-004 REQ0, REQ1  input  1 each  transfer request from requester 0/1; level, held until its DONE.
REQ-005 TX_DATA0, TX_DATA1  input  8 each  byte to send for requester 0/1.
REQ-006 GNT0, GNT1  output  1 each  one-cycle pulse: transfer of that requester started.
REQ-007 DONE0, DONE1  output  1 each  one-cycle pulse: transfer of that requester complete, RX_DATA valid.
REQ-008 RX_DATA  output  8  last received byte, shared; held until next DONE.
REQ-009 BUSY  output  1  high from grant cycle through DONE cycle.
REQ-010 S_CLK  output  1  SPI clock; mode 0, idle low.
REQ-011 CS  output  1  slave select, active low.
REQ-012 MOSI  output  1  serial out, MSB first.
REQ-013 MISO  input  1  serial in, MSB first.

Function
REQ-014 FSM states IDLE, SETUP, SHIFT, HOLD, DONE; outside reset, exactly one state is active.
REQ-015 IDLE: on a CLK edge sampling any REQ high, the winner's TX_DATA shall be latched and the FSM shall enter SETUP.
REQ-016 In the first SETUP cycle: CS=0, BUSY=1, the winner's GNT pulses for exactly one cycle, MOSI = latched bit 7.
REQ-017 SETUP lasts CLK_DIV cycles with S_CLK=0, then SHIFT.
REQ-018 SHIFT: 8 bits, each 2*CLK_DIV cycles; S_CLK low for the first CLK_DIV cycles, high for the next CLK_DIV.
REQ-019 MISO sampled into the receive shift register on the CLK edge at which S_CLK goes high.
REQ-020 MOSI advances to the next lower bit on the CLK edge at which S_CLK goes low (bits 6..0); it is stable across each rising edge.
REQ-021 After bit 0's high phase: S_CLK=0, HOLD for CLK_DIV cycles with CS still 0.
REQ-022 Total CS-low time per transfer = 18*CLK_DIV cycles; exactly 8 S_CLK rising edges.
REQ-023 DONE state, one cycle: CS=1, RX_DATA = received byte, owner's DONE pulses, BUSY=1; then IDLE.
REQ-024 IDLE drives CS=1, S_CLK=0, BUSY=0; at least 2 cycles with CS high between back-to-back transfers (DONE + IDLE).
REQ-025 REQ or TX_DATA changes after grant shall not affect the running transfer.
REQ-026 A requester still holding REQ in the IDLE cycle after its DONE re-requests (a new transfer).
REQ-027 Simultaneous REQ0 and REQ1 resolved per REQ-032/033; the loser waits, is never dropped.
REQ-028 GNT0/GNT1 and DONE0/DONE1 shall never both be high in the same cycle.

Reset
REQ-029 CLR low asynchronously forces: IDLE, CS=1, S_CLK=0, MOSI=0, GNT*=0, DONE*=0, BUSY=0, RX_DATA=8'h00, priority pointer = requester 0.
REQ-030 Reset mid-transfer aborts it with no DONE; the first transfer after release behaves per REQ-015..023.
REQ-031 Logic leaves reset on the first CLK edge after CLR rises.

Configuration
REQ-032 With macro SPI_ARB_ROUND_ROBIN_EN defined: on contention the requester not served last wins; pointer updates at each grant.
REQ-033 Without SPI_ARB_ROUND_ROBIN_EN: fixed priority, REQ0 always wins contention; no pointer state.

Verification (CLK_DIV=2)
REQ-034 REQ0, TX_DATA0=8'hA5, MISO looped from MOSI -> GNT0 one pulse, CS low 36 cycles, 8 S_CLK rises, DONE0 one pulse, RX_DATA=8'hA5.
REQ-035 REQ1, TX_DATA1=8'h00, slave model returns 8'h3C -> MOSI stays 0, RX_DATA=8'h3C with DONE1, DONE0 stays 0.
REQ-036 REQ0, REQ1 held high for 4 transfers -> grants 0,1,0,1 with macro; 0,0,0,0 without.
REQ-037 REQ1 raised mid REQ0 transfer -> DONE0, then GNT1 after exactly 2 CS-high cycles; RX_DATA updated per transfer.
REQ-038 CLR low during SHIFT bit 4 -> CS=1, S_CLK=0, BUSY=0 immediately, no DONE; next REQ0 with 8'h5A completes normally.
REQ-039 TX_DATA0 changed 8'hFF->8'h00 after GNT0 -> MOSI still shifts 8'hFF.

Source files
------------

// File: rtl/spi_master_arbiter.sv
// Two-requester SPI master (mode 0, MSB first) with a single shared serial port.
// Define SPI_ARB_ROUND_ROBIN_EN for round-robin contention; otherwise requester 0 always wins.
module spi_master_arbiter #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] tx_data0,
  input  logic [7:0] tx_data1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       s_clk,
  output logic       cs,
  output logic       mosi,
  input  logic       miso
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t     state_r, state_n;
  logic [7:0] cnt_r, cnt_n;
  logic [2:0] bit_r, bit_n;
  logic [6:0] tx_sh_r, tx_sh_n;
  logic [7:0] rx_sh_r, rx_sh_n;
  logic [7:0] rx_data_r, rx_data_n;
  logic       owner_r, owner_n;
  logic       cs_r, cs_n;
  logic       s_clk_r, s_clk_n;
  logic       mosi_r, mosi_n;
  logic       busy_r, busy_n;
  logic       gnt0_r, gnt0_n;
  logic       gnt1_r, gnt1_n;
  logic       done0_r, done0_n;
  logic       done1_r, done1_n;
  logic       win1_s;

`ifdef SPI_ARB_ROUND_ROBIN_EN
  // prio_r names the requester that wins the next contention
  logic prio_r, prio_n;

  // Winner selection: round robin on contention
  always_comb begin
    if (req0 && req1) begin
      win1_s = prio_r;
    end else begin
      win1_s = req1;
    end
  end

  // Priority pointer register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      prio_r <= 1'b0;
    end else begin
      prio_r <= prio_n;
    end
  end
`else
  // Winner selection: requester 0 has fixed priority
  always_comb begin
    win1_s = req1 & ~req0;
  end
`endif

  // Next-state and next-output logic
  always_comb begin
    state_n   = state_r;
    cnt_n     = cnt_r;
    bit_n     = bit_r;
    tx_sh_n   = tx_sh_r;
    rx_sh_n   = rx_sh_r;
    rx_data_n = rx_data_r;
    owner_n   = owner_r;
    cs_n      = cs_r;
    s_clk_n   = s_clk_r;
    mosi_n    = mosi_r;
    busy_n    = busy_r;
    gnt0_n    = 1'b0;
    gnt1_n    = 1'b0;
    done0_n   = 1'b0;
    done1_n   = 1'b0;
`ifdef SPI_ARB_ROUND_ROBIN_EN
    prio_n    = prio_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (req0 || req1) begin
          state_n = ST_SETUP;
          cnt_n   = DIV_LAST;
          owner_n = win1_s;
          tx_sh_n = win1_s ? tx_data1[6:0] : tx_data0[6:0];
          mosi_n  = win1_s ? tx_data1[7] : tx_data0[7];
          cs_n    = 1'b0;
          busy_n  = 1'b1;
          gnt0_n  = ~win1_s;
          gnt1_n  = win1_s;
`ifdef SPI_ARB_ROUND_ROBIN_EN
          prio_n  = ~win1_s;
`endif
        end else begin
          cs_n    = 1'b1;
          s_clk_n = 1'b0;
          busy_n  = 1'b0;
          mosi_n  = 1'b0;
        end
      end
      ST_SETUP: begin
        if (cnt_r == 8'd0) begin
          state_n = ST_SHIFT;
          cnt_n   = DIV_LAST;
          bit_n   = 3'd7;
        end else begin
          cnt_n = cnt_r - 8'd1;
        end
      end
      ST_SHIFT: begin
        // each bit: CLK_DIV cycles low, then CLK_DIV cycles high
        if (cnt_r != 8'd0) begin
          cnt_n = cnt_r - 8'd1;
        end else if (!s_clk_r) begin
          s_clk_n = 1'b1;
          cnt_n   = DIV_LAST;
          rx_sh_n = {rx_sh_r[6:0], miso};
        end else begin
          s_clk_n = 1'b0;
          cnt_n   = DIV_LAST;
          if (bit_r == 3'd0) begin
            state_n = ST_HOLD;
          end else begin
            bit_n   = bit_r - 3'd1;
            mosi_n  = tx_sh_r[6];
            tx_sh_n = {tx_sh_r[5:0], 1'b0};
          end
        end
      end
      ST_HOLD: begin
        if (cnt_r == 8'd0) begin
          state_n   = ST_DONE;
          cs_n      = 1'b1;
          mosi_n    = 1'b0;
          rx_data_n = rx_sh_r;
          done0_n   = ~owner_r;
          done1_n   = owner_r;
        end else begin
          cnt_n = cnt_r - 8'd1;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
        cs_n    = 1'b1;
        s_clk_n = 1'b0;
        busy_n  = 1'b0;
      end
      default: begin
        state_n = ST_IDLE;
        cs_n    = 1'b1;
        s_clk_n = 1'b0;
        busy_n  = 1'b0;
        mosi_n  = 1'b0;
      end
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 8'd0;
      bit_r     <= 3'd0;
      tx_sh_r   <= 7'd0;
      rx_sh_r   <= 8'd0;
      rx_data_r <= 8'd0;
      owner_r   <= 1'b0;
      cs_r      <= 1'b1;
      s_clk_r   <= 1'b0;
      mosi_r    <= 1'b0;
      busy_r    <= 1'b0;
      gnt0_r    <= 1'b0;
      gnt1_r    <= 1'b0;
      done0_r   <= 1'b0;
      done1_r   <= 1'b0;
    end else begin
      state_r   <= state_n;
      cnt_r     <= cnt_n;
      bit_r     <= bit_n;
      tx_sh_r   <= tx_sh_n;
      rx_sh_r   <= rx_sh_n;
      rx_data_r <= rx_data_n;
      owner_r   <= owner_n;
      cs_r      <= cs_n;
      s_clk_r   <= s_clk_n;
      mosi_r    <= mosi_n;
      busy_r    <= busy_n;
      gnt0_r    <= gnt0_n;
      gnt1_r    <= gnt1_n;
      done0_r   <= done0_n;
      done1_r   <= done1_n;
    end
  end

  assign gnt0    = gnt0_r;
  assign gnt1    = gnt1_r;
  assign done0   = done0_r;
  assign done1   = done1_r;
  assign rx_data = rx_data_r;
  assign busy    = busy_r;
  assign s_clk   = s_clk_r;
  assign cs      = cs_r;
  assign mosi    = mosi_r;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Bench for spi_master_arbiter: transfer monitor, arbitration/transfer reference model,
// table vectors, randomized vectors and hand-written corner sequences.
module tb_spi_master_arbiter;
  localparam int D = 2;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] tx_data0 = 8'h00, tx_data1 = 8'h00;
  logic       gnt0, gnt1, done0, done1, busy, s_clk, cs, mosi, miso;
  logic [7:0] rx_data;

  always #5 clk = ~clk;

  spi_master_arbiter #(.CLK_DIV(D)) dut (
    .clk(clk), .clr(clr), .req0(req0), .req1(req1),
    .tx_data0(tx_data0), .tx_data1(tx_data1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rx_data(rx_data), .busy(busy), .s_clk(s_clk), .cs(cs),
    .mosi(mosi), .miso(miso)
  );

  int n_tests = 0, n_fail = 0, inv_err = 0;

  // Slave model: either loops MOSI back or presents slave_byte MSB first
  logic       loop_en = 1'b0;
  logic [7:0] slave_byte = 8'h00;
  int         rises = 0;
  assign miso = loop_en ? mosi : ((rises < 8) ? slave_byte[3'(7 - rises)] : 1'b0);

  typedef struct {
    logic       owner;
    logic       done_owner;
    int         gnt_cnt;
    int         cs_low;
    int         busy_cnt;
    int         rise_cnt;
    int         gap;
    logic [7:0] mosi_byte;
    logic [7:0] rx;
  } rec_t;

  typedef struct {
    logic       owner;
    logic [7:0] tx;
    logic [7:0] rx;
  } exp_t;

  rec_t got_q[$];
  exp_t exp_q[$];

  // Transfer monitor, sampled on the falling clock edge
  logic       m_owner = 1'b0, prev_s = 1'b0, prev_g = 1'b0, prev_d = 1'b0;
  int         m_cs_low = 0, m_busy = 0, m_high = 0, m_gnt = 0, m_gap = 0;
  logic [7:0] m_cap = 8'h00;

  initial begin
    forever begin
      @(negedge clk);
      if (!clr) begin
        rises = 0; m_cs_low = 0; m_busy = 0; m_high = 0; m_gnt = 0;
        prev_s = 1'b0; prev_g = 1'b0; prev_d = 1'b0; m_cap = 8'h00;
      end else begin
        if ((gnt0 || gnt1) && !prev_g) begin
          m_owner = gnt1; m_gap = m_high; m_cs_low = 0; m_busy = 0;
          rises = 0; m_cap = 8'h00; m_gnt = 0;
          if (cs !== 1'b0 || busy !== 1'b1) begin
            inv_err++;
            $display("FAIL gnt_cycle: cs=%0b busy=%0b, required cs=0 busy=1", cs, busy);
          end
        end
        if (gnt0 && gnt1) begin
          inv_err++;
          $display("FAIL gnt_both: gnt0=1 gnt1=1, required at most one");
        end
        if (done0 && done1) begin
          inv_err++;
          $display("FAIL done_both: done0=1 done1=1, required at most one");
        end
        if ((done0 || done1) && prev_d) begin
          inv_err++;
          $display("FAIL done_width: done high two cycles, required one");
        end
        if (gnt0 || gnt1) m_gnt++;
        if (!cs) begin
          m_cs_low++; m_high = 0;
        end else begin
          m_high++;
        end
        if (busy) m_busy++;
        if (s_clk && !prev_s) begin
          rises++; m_cap = {m_cap[6:0], mosi};
        end
        if ((done0 || done1) && !prev_d)
          got_q.push_back('{m_owner, done1, m_gnt, m_cs_low, m_busy, rises, m_gap, m_cap, rx_data});
        prev_s = s_clk; prev_g = gnt0 || gnt1; prev_d = done0 || done1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  // Reference model: who wins each grant, and what each transfer must carry
`ifdef SPI_ARB_ROUND_ROBIN_EN
  logic prio_m = 1'b0;
`endif

  task automatic plan(input logic r0, input logic r1, input int n, input logic hold);
    logic a0, a1, w;
    logic [7:0] t;
    a0 = r0; a1 = r1;
    for (int k = 0; k < n; k++) begin
`ifdef SPI_ARB_ROUND_ROBIN_EN
      w = (a0 && a1) ? prio_m : a1;
      prio_m = ~w;
`else
      w = !a0;
`endif
      t = w ? tx_data1 : tx_data0;
      exp_q.push_back('{w, t, loop_en ? t : slave_byte});
      if (!hold) begin
        if (w) a1 = 1'b0;
        else a0 = 1'b0;
      end
    end
  endtask

  task automatic wait_dones(input int n, input logic hold);
    int d, c;
    d = 0; c = 0;
    while (d < n && c < 60 * n + 40) begin
      @(negedge clk);
      c++;
      if (done0 || done1) begin
        d++;
        if (hold) begin
          if (d >= n) begin req0 = 1'b0; req1 = 1'b0; end
        end else begin
          if (done0) req0 = 1'b0;
          if (done1) req1 = 1'b0;
        end
      end
    end
    if (d < n) begin
      check("timeout_dones", d, n);
      req0 = 1'b0; req1 = 1'b0;
    end
  endtask

  task automatic wait_rises(input int k);
    int c;
    c = 0;
    while (rises < k && c < 200) begin
      @(negedge clk);
      c++;
    end
    if (rises < k) check("timeout_rises", rises, k);
  endtask

  task automatic compare_batch();
    rec_t g;
    exp_t e;
    int   i;
    check("record_count", got_q.size(), exp_q.size());
    i = 0;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check("owner", g.owner, e.owner);
      check("done_owner", g.done_owner, e.owner);
      check("gnt_pulses", g.gnt_cnt, 1);
      check("cs_low_cycles", g.cs_low, 18 * D);
      check("busy_cycles", g.busy_cnt, 18 * D + 1);
      check("sclk_rises", g.rise_cnt, 8);
      check("mosi_byte", g.mosi_byte, e.tx);
      check("rx_data", g.rx, e.rx);
      if (i > 0) check("cs_high_gap", g.gap, 2);
      i++;
    end
    got_q.delete();
    exp_q.delete();
    check("idle_cs", cs, 1'b1);
    check("idle_busy", busy, 1'b0);
  endtask

  task automatic run_batch(input logic r0, input logic r1, input int n, input logic hold, input int exp_first);
    plan(r0, r1, n, hold);
    req0 = r0; req1 = r1;
    wait_dones(n, hold);
    repeat (3) @(negedge clk);
    if (exp_first >= 0 && got_q.size() > 0) check("tbl_first_owner", got_q[0].owner, exp_first);
    compare_batch();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_cs"}, cs, 1'b1);
    check({tag, "_sclk"}, s_clk, 1'b0);
    check({tag, "_mosi"}, mosi, 1'b0);
    check({tag, "_gnt"}, {gnt1, gnt0}, 2'b00);
    check({tag, "_done"}, {done1, done0}, 2'b00);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_rx"}, rx_data, 8'h00);
  endtask

  typedef struct {
    logic       r0;
    logic       r1;
    logic [7:0] t0;
    logic [7:0] t1;
    logic [7:0] sl;
    logic       lp;
    int         exp_first;
  } vec_t;

  vec_t tbl[6];
  logic [1:0] rmask;

  initial begin
    tbl[0] = '{1'b1, 1'b0, 8'hA5, 8'h00, 8'h00, 1'b1, 0};
    tbl[1] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h3C, 1'b0, 1};
    tbl[2] = '{1'b1, 1'b1, 8'h5A, 8'hC3, 8'h96, 1'b0, 0};
    tbl[3] = '{1'b1, 1'b0, 8'h81, 8'h00, 8'h00, 1'b1, 0};
`ifdef SPI_ARB_ROUND_ROBIN_EN
    tbl[4] = '{1'b1, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b1, 1};
`else
    tbl[4] = '{1'b1, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b1, 0};
`endif
    tbl[5] = '{1'b1, 1'b0, 8'h01, 8'h00, 8'h80, 1'b0, 0};

    repeat (3) @(negedge clk);
    check_reset_state("reset");
    clr = 1'b1;
    @(negedge clk);

    // Both requesters held for four transfers: 0,1,0,1 or 0,0,0,0
    tx_data0 = 8'h12; tx_data1 = 8'h34; loop_en = 1'b1;
    run_batch(1'b1, 1'b1, 4, 1'b1, 0);

    for (int i = 0; i < 6; i++) begin
      tx_data0 = tbl[i].t0; tx_data1 = tbl[i].t1;
      slave_byte = tbl[i].sl; loop_en = tbl[i].lp;
      run_batch(tbl[i].r0, tbl[i].r1, int'(tbl[i].r0) + int'(tbl[i].r1), 1'b0, tbl[i].exp_first);
    end

    // Requester 1 arrives in the middle of a requester-0 transfer
    tx_data0 = 8'h3C; tx_data1 = 8'hC5; loop_en = 1'b1;
    plan(1'b1, 1'b0, 1, 1'b0);
    plan(1'b0, 1'b1, 1, 1'b0);
    req0 = 1'b1;
    wait_rises(3);
    req1 = 1'b1;
    wait_dones(2, 1'b0);
    repeat (3) @(negedge clk);
    compare_batch();

    // TX data changed after the grant must not alter the shifted byte
    tx_data0 = 8'hFF; loop_en = 1'b1;
    plan(1'b1, 1'b0, 1, 1'b0);
    req0 = 1'b1;
    for (int c = 0; c < 20 && !gnt0; c++) @(negedge clk);
    check("gnt0_seen", gnt0, 1'b1);
    tx_data0 = 8'h00;
    wait_dones(1, 1'b0);
    repeat (3) @(negedge clk);
    compare_batch();

    for (int i = 0; i < 12; i++) begin
      rmask = 2'($urandom_range(1, 3));
      tx_data0 = 8'($urandom); tx_data1 = 8'($urandom);
      slave_byte = 8'($urandom); loop_en = 1'($urandom_range(0, 1));
      run_batch(rmask[0], rmask[1], int'(rmask[0]) + int'(rmask[1]), 1'b0, -1);
    end

    // Reset in the middle of bit 4 aborts the transfer without DONE
    tx_data0 = 8'h33; loop_en = 1'b1;
    req0 = 1'b1;
    wait_rises(3);
    repeat (3) @(negedge clk);
    #1 clr = 1'b0;
    #1 check_reset_state("abort");
    req0 = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_done", got_q.size(), 0);
    got_q.delete();
    clr = 1'b1;
`ifdef SPI_ARB_ROUND_ROBIN_EN
    prio_m = 1'b0;
`endif
    tx_data0 = 8'h5A;
    run_batch(1'b1, 1'b0, 1, 1'b0, 0);

    check("monitor_invariants", inv_err, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
